imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Write-side counterpart of the instruction memory: accepts a byte stream
//   (valid/ready), assembles big-endian 32-bit MIPS instruction words and
//   writes them sequentially into the instruction RAM from word 0 upward.
//   Holds the core in reset while loading so fetch never sees a partial image.
// PARAMETERS
//   DEPTH   64  instruction RAM depth in words
//   AW      6   word-index width, clog2(DEPTH)
// PORTS
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      1-cycle pulse: begin load (honoured in IDLE/DONE only)
//   abort       in   1      return to IDLE; no further writes
//   nwords      in   AW+1   words to load, latched on start; 0 => DEPTH
//   byte_in     in   8      stream byte
//   byte_valid  in   1      byte_in valid
//   byte_ready  out  1      loader accepts byte this cycle
//   we          out  1      RAM write enable (1 cycle per word)
//   waddr       out  32     RAM word index (zero-extended; same index as read port)
//   wd          out  32     RAM write data
//   busy        out  1      load in progress
//   cpu_hold    out  1      hold core in reset; equals busy
//   done        out  1      load complete; held until next start or abort
//   csum        out  32     XOR of all words written this load
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE; byte_ready, we, busy, cpu_hold, done
//     =0; waddr, wd, csum, word/byte counters =0.
//   - FSM states: IDLE, RECV, WRITE, DONE.
//     IDLE/DONE --start--> RECV: latch nwords (0 => DEPTH), word_cnt=0,
//       byte_cnt=0, csum=0, done=0.
//     RECV: byte_ready=1. Byte accepted when byte_valid & byte_ready.
//       byte_cnt 0..3 fills bits [31:24],[23:16],[15:8],[7:0] (big-endian).
//       On accepting byte_cnt==3 -> WRITE.
//     WRITE (exactly 1 cycle): byte_ready=0; we=1, waddr=word_cnt, wd=word.
//       csum^=word; word_cnt++. If word_cnt+1==count -> DONE, else RECV.
//     DONE: done=1, busy=0; start re-enters RECV.
//   - Latency: 4th byte accepted at edge k; we high in cycle k..k+1 (registered,
//     one cycle after acceptance); next byte acceptable from edge k+2.
//   - we is registered and high for exactly one cycle per word; never in
//     IDLE/DONE. waddr never exceeds count-1 < DEPTH (no wrap).
//   - nwords > DEPTH clamps to DEPTH.
//   - abort (any state, priority over start and byte accept): next state IDLE,
//     busy=done=we=0; partial word discarded; already-written words stay.
//   - start while busy (RECV/WRITE): ignored.
//   - byte_valid outside RECV: ignored, not consumed (byte_ready=0).
//   - Mid-load rst_n assertion: immediate return to reset values; resumes only
//     on a new start.
// TESTING
//   1. nwords=2, bytes 20 08 00 05 8C 09 00 00 -> we at waddr 0 wd=0x20080005,
//      waddr 1 wd=0x8C090000; done=1; csum=0xAC010005.
//   2. nwords=0 -> exactly 64 writes waddr 0..63, done after last; no 65th we.
//   3. byte_valid toggled randomly 50% -> same words as case 1; byte_ready=0
//      in WRITE cycle; cpu_hold=1 from start until done.
//   4. abort after 6 bytes of case 1 -> one write (waddr 0) only, busy=0,
//      done=0; following start reloads from waddr 0.
//   5. start pulsed during RECV -> ignored, counters unchanged; rst_n low
//      mid-word -> all outputs to reset values at once.
//   6. nwords=100 -> clamped, 64 writes; back-to-back start after done ->
//      csum cleared, second load correct.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream instruction RAM loader: packs big-endian bytes into 32-bit words,
// writes them from word 0 upward and keeps the core held in reset meanwhile.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW:0]   nwords,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          we,
  output logic [31:0]   waddr,
  output logic [31:0]   wd,
  output logic          busy,
  output logic          cpu_hold,
  output logic          done,
  output logic [31:0]   csum
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_e;

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneW   = (AW+1)'(1);

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   wordCnt_q, wordCnt_d;
  logic [1:0]    byteCnt_q, byteCnt_d;
  logic [23:0]   shift_q, shift_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wd_q, wd_d;
  logic [31:0]   csum_q, csum_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      wordCnt_q <= '0;
      byteCnt_q <= '0;
      shift_q   <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wd_q      <= '0;
      csum_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wordCnt_q <= wordCnt_d;
      byteCnt_q <= byteCnt_d;
      shift_q   <= shift_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wd_q      <= wd_d;
      csum_q    <= csum_d;
    end
  end

  // Abort overrides everything, including a byte offered in the same cycle.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wordCnt_d = wordCnt_q;
    byteCnt_d = byteCnt_q;
    shift_d   = shift_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wd_d      = wd_q;
    csum_d    = csum_q;
    byte_ready = (state_q == RECV) && !abort;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d   = RECV;
            count_d   = (nwords == '0 || nwords > DepthW) ? DepthW : nwords;
            wordCnt_d = '0;
            byteCnt_d = '0;
            csum_d    = '0;
          end
        end
        RECV: begin
          if (byte_valid) begin
            shift_d   = {shift_q[15:0], byte_in};
            byteCnt_d = byteCnt_q + 2'd1;
            if (byteCnt_q == 2'd3) begin
              we_d    = 1'b1;
              waddr_d = wordCnt_q[AW-1:0];
              wd_d    = {shift_q, byte_in};
              state_d = WRITE;
            end
          end
        end
        WRITE: begin
          csum_d    = csum_q ^ wd_q;
          wordCnt_d = wordCnt_q + OneW;
          state_d   = (wordCnt_q + OneW == count_q) ? DONE : RECV;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign we       = we_q;
  assign waddr    = {{(32-AW){1'b0}}, waddr_q};
  assign wd       = wd_q;
  assign busy     = (state_q == RECV) || (state_q == WRITE);
  assign cpu_hold = busy;
  assign done     = (state_q == DONE);
  assign csum     = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected RAM writes are queued as
// bytes are sent and a negedge monitor pops them whenever we is seen.
module tb_imem_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, byte_valid;
  logic [AW:0] nwords;
  logic [7:0]  byte_in;
  logic        byte_ready, we, busy, cpu_hold, done;
  logic [31:0] waddr, wd, csum;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .nwords(nwords),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .we(we), .waddr(waddr), .wd(wd), .busy(busy), .cpu_hold(cpu_hold),
    .done(done), .csum(csum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expQ[$];
  int          compared = 0;
  int          mismatched = 0;
  int          writesSeen = 0;
  int          expCount;
  logic [31:0] expCsum;
  logic [31:0] words[DEPTH];
  bit          gapMode = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Every write the DUT makes must match the next queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (we === 1'b1) begin
      writesSeen++;
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_write: got waddr %h wd %h expected no write", waddr, wd);
      end else begin
        e = expQ.pop_front();
        checkOutput("waddr", waddr, 32'(e.addr));
        checkOutput("wd", wd, e.data);
        checkOutput("ready_in_write", 32'(byte_ready), 32'd0);
        checkOutput("hold_in_write", 32'(cpu_hold), 32'd1);
        checkOutput("done_in_write", 32'(done), 32'd0);
      end
    end
  end

  task automatic pulseStart(input int n);
    start  = 1'b1;
    nwords = (AW+1)'(n);
    @(posedge clk); #1;
    start  = 1'b0;
    checkOutput("hold_after_start", 32'(cpu_hold), 32'd1);
  endtask

  task automatic sendByte(input logic [7:0] b);
    bit ok = 1'b0;
    bit acc;
    for (int t = 0; t < 200; t++) begin
      byte_valid = gapMode ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_in    = byte_valid ? b : 8'($urandom);
      @(negedge clk);
      acc = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    byte_valid = 1'b0;
    if (!ok) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL byte_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic sendRange(input int first, input int last);
    logic [31:0] w;
    for (int i = first; i < last; i++) begin
      w = words[i/4];
      sendByte(w[31-8*(i%4) -: 8]);
      if (i % 4 == 3 && i / 4 < expCount) expQ.push_back('{i/4, w});
    end
  endtask

  task automatic beginLoad(input int n);
    expCount = (n == 0 || n > DEPTH) ? DEPTH : n;
    expCsum  = '0;
    for (int i = 0; i < expCount; i++) expCsum ^= words[i];
    writesSeen = 0;
    pulseStart(n);
  endtask

  task automatic finishLoad();
    bit seen = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL done_timeout: got done=0 expected done=1");
    end
    @(negedge clk);
    checkOutput("busy_at_done", 32'(busy), 32'd0);
    checkOutput("hold_at_done", 32'(cpu_hold), 32'd0);
    checkOutput("csum", csum, expCsum);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_held", 32'(done), 32'd1);
    checkOutput("write_count", 32'(writesSeen), 32'(expCount));
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
  endtask

  task automatic applyStimulus(input int n, input bit gaps);
    gapMode = gaps;
    beginLoad(n);
    sendRange(0, expCount * 4);
    finishLoad();
    gapMode = 1'b0;
  endtask

  task automatic randomWords();
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
  endtask

  task automatic case1Words();
    words[0] = 32'h2008_0005;
    words[1] = 32'h8C09_0000;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, 32'(byte_ready), 32'd0);
    checkOutput({tag, "_we"},    32'(we), 32'd0);
    checkOutput({tag, "_busy"},  32'(busy), 32'd0);
    checkOutput({tag, "_hold"},  32'(cpu_hold), 32'd0);
    checkOutput({tag, "_done"},  32'(done), 32'd0);
    checkOutput({tag, "_waddr"}, waddr, 32'd0);
    checkOutput({tag, "_wd"},    wd, 32'd0);
    checkOutput({tag, "_csum"},  csum, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; nwords = '0;
    byte_in = '0; byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #6 checkResetValues("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] two-word load");
    case1Words();
    applyStimulus(2, 1'b0);
    checkOutput("csum_case1", csum, 32'hAC01_0005);

    $display("[TB] full-depth load with nwords=0");
    randomWords();
    applyStimulus(0, 1'b0);

    $display("[TB] two-word load with random byte_valid");
    case1Words();
    applyStimulus(2, 1'b1);

    $display("[TB] abort after six bytes");
    case1Words();
    beginLoad(2);
    sendRange(0, 6);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_ready", 32'(byte_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_writes", 32'(writesSeen), 32'd1);
    checkOutput("abort_queue", 32'(expQ.size()), 32'd0);
    applyStimulus(2, 1'b0);

    $display("[TB] start pulsed mid-load is ignored");
    randomWords();
    beginLoad(2);
    sendRange(0, 2);
    start = 1'b1;
    nwords = 7'd5;
    @(posedge clk); #1;
    start = 1'b0;
    sendRange(2, 8);
    finishLoad();

    $display("[TB] reset asserted mid-word");
    randomWords();
    beginLoad(3);
    sendRange(0, 6);
    #2 rst_n = 1'b0;
    #1 checkResetValues("midreset");
    checkOutput("midreset_queue", 32'(expQ.size()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] clamped load then back-to-back reload");
    randomWords();
    applyStimulus(100, 1'b1);
    randomWords();
    applyStimulus(5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
